// File: rtl/wf_neopixel_frame_ctrl_pkg.sv
// Shared constants for the neopixel double-buffered frame controller:
// pixel width, FSM encodings and WF_neopixel_if wire timing at 12 MHz.
package wf_neopixel_frame_ctrl_pkg;

   localparam int unsigned DEF_PIX_W = 24;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_FILL      = 2'd1;
   localparam logic [1:0] ST_WAIT_SWAP = 2'd2;

   // WF_neopixel_if bit timing in 12 MHz clocks (1.25 us bit, >50 us reset)
   localparam int unsigned BIT_PERIOD = 15;
   localparam int unsigned BIT0_HIGH  = 4;
   localparam int unsigned BIT1_HIGH  = 8;
   localparam int unsigned NEO_RESET  = 660;

   typedef struct packed {
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
   } grb_t;

endpackage

// File: rtl/wf_pixel_ram_dp.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// Read register can be forced to zero for out-of-range pixel reads.
module wf_pixel_ram_dp #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 24
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   input  logic          rd_clr_i,
   output logic [DW-1:0] rdata_o
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rdata_q <= '0;
      else if (rd_clr_i) rdata_q <= '0;
      else               rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wf_neopixel_frame_ctrl.sv
// Double-buffered neopixel frame controller: producer writes the back buffer,
// WF_neopixel_if reads the front buffer, buffers swap only in the reset gap.
module wf_neopixel_frame_ctrl
   import wf_neopixel_frame_ctrl_pkg::*;
#(
   parameter int unsigned NUM_PIXELS = 8,
   parameter int unsigned PIX_W      = DEF_PIX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [7:0]       wr_addr,
   input  logic [PIX_W-1:0] wr_data,
   output logic             wr_ready,
   input  logic             fill_req,
   input  logic [PIX_W-1:0] fill_data,
   input  logic             commit,
   input  logic [7:0]       np_rd_addr,
   output logic [PIX_W-1:0] np_rd_data,
   output logic             active_buf,
   output logic             frame_swap,
   output logic             wr_err
);

   localparam int unsigned IDX_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int unsigned RAM_AW = IDX_W + 1;
   localparam logic [7:0]  NPIX8  = 8'(NUM_PIXELS);

   logic [1:0]       state_q, state_d;
   logic             active_buf_q, active_buf_d;
   logic             commit_q, commit_d;
   logic [IDX_W-1:0] fill_cnt_q, fill_cnt_d;
   logic [PIX_W-1:0] fill_data_q, fill_data_d;
   logic             wr_ready_q, wr_ready_d;
   logic             frame_swap_q, frame_swap_d;
   logic             wr_err_q, wr_err_d;
   logic [7:0]       np_rd_addr_q;

   logic              gap_start_c;
   logic              wr_ok_c;
   logic              ram_we_c;
   logic [RAM_AW-1:0] ram_waddr_c;
   logic [PIX_W-1:0]  ram_wdata_c;

   // A frame gap begins when the reader wraps back to pixel 0
   assign gap_start_c = (np_rd_addr_q != 8'd0) && (np_rd_addr == 8'd0);
   assign wr_ok_c     = wr_en && wr_ready_q && (wr_addr < NPIX8);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         active_buf_q <= 1'b0;
         commit_q     <= 1'b0;
         fill_cnt_q   <= '0;
         fill_data_q  <= '0;
         wr_ready_q   <= 1'b1;
         frame_swap_q <= 1'b0;
         wr_err_q     <= 1'b0;
         np_rd_addr_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         active_buf_q <= active_buf_d;
         commit_q     <= commit_d;
         fill_cnt_q   <= fill_cnt_d;
         fill_data_q  <= fill_data_d;
         wr_ready_q   <= wr_ready_d;
         frame_swap_q <= frame_swap_d;
         wr_err_q     <= wr_err_d;
         np_rd_addr_q <= np_rd_addr;
      end
   end

   always_comb begin
      state_d      = state_q;
      active_buf_d = active_buf_q;
      commit_d     = commit_q;
      fill_cnt_d   = fill_cnt_q;
      fill_data_d  = fill_data_q;
      frame_swap_d = 1'b0;
      wr_err_d     = wr_en && !wr_ok_c;
      ram_we_c     = wr_ok_c;
      ram_waddr_c  = {~active_buf_q, wr_addr[IDX_W-1:0]};
      ram_wdata_c  = wr_data;

      case (state_q)
         ST_IDLE: begin
            if (fill_req) begin
               fill_data_d = fill_data;
               fill_cnt_d  = '0;
               commit_d    = commit;
               state_d     = ST_FILL;
            end else if (commit) begin
               state_d = ST_WAIT_SWAP;
            end
         end
         ST_FILL: begin
            ram_we_c    = 1'b1;
            ram_waddr_c = {~active_buf_q, fill_cnt_q};
            ram_wdata_c = fill_data_q;
            if (commit) commit_d = 1'b1;
            if (fill_cnt_q == IDX_W'(NUM_PIXELS - 1)) begin
               state_d  = (commit_q || commit) ? ST_WAIT_SWAP : ST_IDLE;
               commit_d = 1'b0;
            end else begin
               fill_cnt_d = fill_cnt_q + IDX_W'(1);
            end
         end
         ST_WAIT_SWAP: begin
            if (gap_start_c) begin
               active_buf_d = ~active_buf_q;
               frame_swap_d = 1'b1;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      wr_ready_d = (state_d == ST_IDLE);
   end

   wf_pixel_ram_dp #(
      .AW (RAM_AW),
      .DW (PIX_W)
   ) u_ram (
      .clk      (clk),
      .rst_n    (rst_n),
      .we_i     (ram_we_c),
      .waddr_i  (ram_waddr_c),
      .wdata_i  (ram_wdata_c),
      .raddr_i  ({active_buf_q, np_rd_addr[IDX_W-1:0]}),
      .rd_clr_i (np_rd_addr >= NPIX8),
      .rdata_o  (np_rd_data)
   );

   assign wr_ready   = wr_ready_q;
   assign active_buf = active_buf_q;
   assign frame_swap = frame_swap_q;
   assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_wf_neopixel_frame_ctrl.sv
// Bench for wf_neopixel_frame_ctrl (NUM_PIXELS=4): directed vector table,
// a mid-swap reset sequence, then random traffic against a frame-level model.
module tb_wf_neopixel_frame_ctrl;

   localparam int unsigned NP = 4;
   localparam logic L0 = 1'b0;
   localparam logic L1 = 1'b1;
   localparam logic [23:0] Z24 = 24'h0;

   typedef struct {
      logic        we;
      logic [7:0]  wa;
      logic [23:0] wd;
      logic        fr;
      logic [23:0] fd;
      logic        cm;
      logic [7:0]  na;
      logic        ck;
      logic [23:0] rd;
      logic        rdy;
      logic        act;
      logic        sw;
      logic        err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [23:0] wr_data;
   logic        wr_ready;
   logic        fill_req;
   logic [23:0] fill_data;
   logic        commit;
   logic [7:0]  np_rd_addr;
   logic [23:0] np_rd_data;
   logic        active_buf;
   logic        frame_swap;
   logic        wr_err;

   int n_checks = 0;
   int n_fail   = 0;

   // frame-level reference: two pixel arrays plus pending work counters
   logic [23:0] mb [2][NP];
   bit          mk [2][NP];
   bit          m_act;
   int          m_fill_left;
   logic [23:0] m_col;
   bit          m_pend;
   bit          m_wait;
   logic [7:0]  m_prev;

   vec_t tbl[$];

   wf_neopixel_frame_ctrl #(.NUM_PIXELS(NP), .PIX_W(24)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .fill_req   (fill_req),
      .fill_data  (fill_data),
      .commit     (commit),
      .np_rd_addr (np_rd_addr),
      .np_rd_data (np_rd_data),
      .active_buf (active_buf),
      .frame_swap (frame_swap),
      .wr_err     (wr_err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mkv(input logic we, input logic [7:0] wa, input logic [23:0] wd,
                                input logic fr, input logic [23:0] fd, input logic cm,
                                input logic [7:0] na, input logic ck, input logic [23:0] rd,
                                input logic rdy, input logic act, input logic sw, input logic err);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.fr = fr; v.fd = fd; v.cm = cm; v.na = na;
      v.ck = ck; v.rd = rd; v.rdy = rdy; v.act = act; v.sw = sw; v.err = err;
      return v;
   endfunction

   function automatic vec_t idle_in(input logic [7:0] na);
      return mkv(L0, 8'd0, Z24, L0, Z24, L0, na, L0, Z24, L0, L0, L0, L0);
   endfunction

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      end
   endtask

   task automatic model_reset();
      m_act = 1'b0; m_fill_left = 0; m_pend = 1'b0; m_wait = 1'b0; m_prev = 8'd0;
   endtask

   task automatic model_step(input vec_t v, output vec_t e);
      bit idle, ok, gap, back;
      int idx;
      e      = v;
      idle   = (m_fill_left == 0) && !m_wait;
      back   = ~m_act;
      e.ck   = 1'b1;
      e.rd   = Z24;
      if (v.na < 8'd4) begin
         e.ck = mk[m_act][v.na[1:0]];
         e.rd = mb[m_act][v.na[1:0]];
      end
      ok    = v.we && idle && (v.wa < 8'd4);
      e.err = v.we && !ok;
      if (ok) begin
         mb[back][v.wa[1:0]] = v.wd;
         mk[back][v.wa[1:0]] = 1'b1;
      end
      e.sw = 1'b0;
      gap  = (m_prev != 8'd0) && (v.na == 8'd0);
      if (m_wait) begin
         if (gap) begin
            m_act  = ~m_act;
            e.sw   = 1'b1;
            m_wait = 1'b0;
         end
      end else if (m_fill_left > 0) begin
         idx = NP - m_fill_left;
         mb[back][idx] = m_col;
         mk[back][idx] = 1'b1;
         if (v.cm) m_pend = 1'b1;
         m_fill_left--;
         if (m_fill_left == 0) begin
            m_wait = m_pend;
            m_pend = 1'b0;
         end
      end else if (v.fr) begin
         m_col       = v.fd;
         m_fill_left = NP;
         m_pend      = v.cm;
      end else if (v.cm) begin
         m_wait = 1'b1;
      end
      m_prev = v.na;
      e.rdy  = (m_fill_left == 0) && !m_wait;
      e.act  = m_act;
   endtask

   task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag);
      vec_t me, e;
      @(negedge clk);
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      fill_req = v.fr; fill_data = v.fd; commit = v.cm; np_rd_addr = v.na;
      model_step(v, me);
      e = use_tbl ? v : me;
      @(posedge clk);
      #1;
      if (e.ck) chk({tag, ".np_rd_data"}, 32'(np_rd_data), 32'(e.rd));
      chk({tag, ".wr_ready"},   32'(wr_ready),   32'(e.rdy));
      chk({tag, ".active_buf"}, 32'(active_buf), 32'(e.act));
      chk({tag, ".frame_swap"}, 32'(frame_swap), 32'(e.sw));
      chk({tag, ".wr_err"},     32'(wr_err),     32'(e.err));
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = 8'd0; wr_data = Z24; fill_req = 1'b0;
      fill_data = Z24; commit = 1'b0; np_rd_addr = 8'd0;
      for (int b = 0; b < 2; b++) for (int p = 0; p < int'(NP); p++) begin
         mb[b][p] = Z24; mk[b][p] = 1'b0;
      end
      m_col = Z24;
      model_reset();

      // reset values
      repeat (2) @(negedge clk);
      chk("reset.wr_ready",   32'(wr_ready),   32'd1);
      chk("reset.active_buf", 32'(active_buf), 32'd0);
      chk("reset.np_rd_data", 32'(np_rd_data), 32'd0);
      chk("reset.frame_swap", 32'(frame_swap), 32'd0);
      chk("reset.wr_err",     32'(wr_err),     32'd0);
      rst_n = 1'b1;

      // out-of-range read, load back buffer, bad writes, commit and swap
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd4, L1, Z24, L1, L0, L0, L0));
      tbl.push_back(mkv(L1, 8'd0, 24'h00FE00, L0, Z24, L0, 8'd0, L0, Z24, L1, L0, L0, L0));
      tbl.push_back(mkv(L1, 8'd1, 24'h0000FE, L0, Z24, L0, 8'd0, L0, Z24, L1, L0, L0, L0));
      tbl.push_back(mkv(L1, 8'd2, 24'hFE0000, L0, Z24, L0, 8'd0, L0, Z24, L1, L0, L0, L0));
      tbl.push_back(mkv(L1, 8'd3, 24'h123456, L0, Z24, L0, 8'd0, L0, Z24, L1, L0, L0, L0));
      tbl.push_back(mkv(L1, 8'd4, 24'hDEAD00, L0, Z24, L0, 8'd0, L0, Z24, L1, L0, L0, L1));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L1, 8'd1, L0, Z24, L0, L0, L0, L0));
      tbl.push_back(mkv(L1, 8'd0, 24'hBADBAD, L0, Z24, L0, 8'd2, L0, Z24, L0, L0, L0, L1));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd3, L0, Z24, L0, L0, L0, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd0, L0, Z24, L1, L1, L1, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd3, L1, 24'h123456, L1, L1, L0, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd0, L1, 24'h00FE00, L1, L1, L0, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd1, L1, 24'h0000FE, L1, L1, L0, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd2, L1, 24'hFE0000, L1, L1, L0, L0));
      // fill + commit together; writes and a second fill_req during FILL are dropped
      tbl.push_back(mkv(L0, 8'd0, Z24, L1, 24'h0A0B0C, L1, 8'd0, L1, 24'h00FE00, L0, L1, L0, L0));
      tbl.push_back(mkv(L1, 8'd1, 24'h777777, L0, Z24, L0, 8'd0, L1, 24'h00FE00, L0, L1, L0, L1));
      tbl.push_back(mkv(L0, 8'd0, Z24, L1, 24'h111111, L0, 8'd0, L1, 24'h00FE00, L0, L1, L0, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd0, L1, 24'h00FE00, L0, L1, L0, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd0, L1, 24'h00FE00, L0, L1, L0, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd1, L1, 24'h0000FE, L0, L1, L0, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd0, L1, 24'h00FE00, L1, L0, L1, L0));
      for (int p = 0; p < 4; p++)
         tbl.push_back(mkv(L0, 8'd0, Z24, L0, Z24, L0, 8'(p), L1, 24'h0A0B0C, L1, L0, L0, L0));
      // commit coinciding with a gap: swap only at the following gap
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L1, 8'd0, L1, 24'h0A0B0C, L0, L0, L0, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd0, L1, 24'h0A0B0C, L0, L0, L0, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd1, L1, 24'h0A0B0C, L0, L0, L0, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd0, L1, 24'h0A0B0C, L1, L1, L1, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L0, 8'd0, L1, 24'h00FE00, L1, L1, L0, L0));
      tbl.push_back(mkv(L0, 8'd0, Z24,       L0, Z24, L1, 8'd1, L1, 24'h0000FE, L0, L1, L0, L0));

      foreach (tbl[i]) run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

      // async reset while waiting to swap abandons the swap
      @(negedge clk);
      wr_en = 1'b0; commit = 1'b0; fill_req = 1'b0; np_rd_addr = 8'd0;
      rst_n = 1'b0;
      #1;
      chk("rstwait.active_buf", 32'(active_buf), 32'd0);
      chk("rstwait.wr_ready",   32'(wr_ready),   32'd1);
      chk("rstwait.frame_swap", 32'(frame_swap), 32'd0);
      chk("rstwait.np_rd_data", 32'(np_rd_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      run_cycle(idle_in(8'd2), 1'b0, "postrst0");
      run_cycle(idle_in(8'd0), 1'b0, "postrst1");
      run_cycle(idle_in(8'd3), 1'b0, "postrst2");

      // random traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         v.we = ($urandom_range(0, 1) == 0);
         v.wa = 8'($urandom_range(0, 5));
         v.wd = 24'($urandom);
         v.fr = ($urandom_range(0, 15) == 0);
         v.fd = 24'($urandom);
         v.cm = ($urandom_range(0, 7) == 0);
         v.na = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 5));
         v.ck = 1'b0; v.rd = Z24; v.rdy = 1'b0; v.act = 1'b0; v.sw = 1'b0; v.err = 1'b0;
         run_cycle(v, 1'b0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
